// File: rtl/f1_pipe_sweep_if.sv
// Handshake/data bundle for f1_pipe_sweep: upstream a/b/c word, downstream x/y result, status.
// Ports: in_mode/in_valid/in_a/in_b/in_c/in_ready driven by the master, the rest by the block.
// The slave modport is the block side; the master modport is the upstream/downstream environment.
interface f1_pipe_sweep_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_mode;
  logic             in_valid;
  logic             out_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] out_cnt_y;
  logic             out_sweep_done;

  modport master (
    output in_mode, in_valid, in_a, in_b, in_c, in_ready,
    input  out_ready, out_valid, out_x, out_y, out_cnt_y, out_sweep_done
  );

  modport slave (
    input  in_mode, in_valid, in_a, in_b, in_c, in_ready,
    output out_ready, out_valid, out_x, out_y, out_cnt_y, out_sweep_done
  );
endinterface

// File: rtl/f1_pipe_sweep.sv
// Lane-wise X = a^b, Y = (X&c)|b in a 2-stage valid/ready pipeline, with an 8-step (a,b,c) sweep mode.
// Latency: word presented in cycle N is visible on out_valid/out_x/out_y after edge N+2; 1 word/cycle.
// Backpressure: holds up to 2 words; out_ready drops combinationally from in_ready when both stages are full.
// Ports: in_clk, in_rst (sync, active-high), bus (slave modport: stream in, result out, Y-ones count, sweep done).
module f1_pipe_sweep #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic              in_clk,
  input logic              in_rst,
  f1_pipe_sweep_if.slave   bus
);
  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  typedef enum logic [1:0] {ST_STREAM, ST_SWEEP, ST_DRAIN, ST_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sweep_start;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_x;
  logic [WIDTH-1:0] s2_y;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic             out_xfer;
  logic             s2_load;
  logic             s1_free;
  logic             stream_rdy;
  logic             inject;
  logic             s1_load;
  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_sat;

  // Handshake: s1 may take a word whenever it is empty or moving into s2 this cycle.
  assign out_xfer   = s2_valid & bus.in_ready;
  assign s2_load    = s1_valid & (!s2_valid | bus.in_ready);
  assign s1_free    = !s1_valid | s2_load;
  assign stream_rdy = s1_free & (state == ST_STREAM) & !bus.in_mode & !in_rst;
  assign inject     = s1_free & (state == ST_SWEEP);
  assign s1_load    = (bus.in_valid & stream_rdy) | inject;

  assign x_nxt = s1_a ^ s1_b;
  assign y_nxt = (x_nxt & s1_c) | s1_b;

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(s2_y[i]);
    end
  end

  // Add in a wider domain so the saturation compare never sees a wrapped value.
  assign cnt_sum = SUM_W'(cnt) + SUM_W'(pc);
  assign cnt_sat = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

  always_comb begin
    state_nxt   = state;
    sweep_start = 1'b0;
    case (state)
      ST_STREAM: begin
        // Sweep starts only once every stream word has left the pipeline.
        if (bus.in_mode && !s1_valid && !s2_valid) begin
          state_nxt   = ST_SWEEP;
          sweep_start = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (inject && idx == 3'd7) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // With s1 empty, the word leaving s2 is the last sweep result.
        if (out_xfer && !s1_valid) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.in_mode) state_nxt = ST_STREAM;
      end
      default: state_nxt = ST_STREAM;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= ST_STREAM;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      idx      <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;

      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;

      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_x     <= x_nxt;
        s2_y     <= y_nxt;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end

      if (sweep_start) idx <= '0;
      else if (inject) idx <= idx + 3'd1;

      if (sweep_start)   cnt <= '0;
      else if (out_xfer) cnt <= cnt_sat;
    end
  end

  // Operand registers carry no reset: they are only observed behind s1_valid.
  always_ff @(posedge in_clk) begin
    if (s1_load) begin
      s1_a <= inject ? {WIDTH{idx[2]}} : bus.in_a;
      s1_b <= inject ? {WIDTH{idx[1]}} : bus.in_b;
      s1_c <= inject ? {WIDTH{idx[0]}} : bus.in_c;
    end
  end

  assign bus.out_ready      = stream_rdy;
  assign bus.out_valid      = s2_valid;
  assign bus.out_x          = s2_x;
  assign bus.out_y          = s2_y;
  assign bus.out_cnt_y      = cnt;
  assign bus.out_sweep_done = (state == ST_DONE);
endmodule
